// File: rtl/mu0_control_unit.sv
// MU0 fetch/execute sequencer with req/ack memory handshake and wait-state timeout.
// Optional: define MU0_CTRL_ILLEGAL_TRAP_EN to trap opcodes 8-15 into HALT with a sticky illegal flag.
module mu0_control_unit #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned TO_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [3:0] opcode,
  input  logic       acc_zero,
  input  logic       acc_neg,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       mem_we,
  output logic       addr_sel,
  output logic       ir_ce,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       acc_ce,
  output logic [1:0] alu_op,
  output logic       halted,
  output logic       bus_err,
  output logic       illegal
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_e;

  localparam logic [3:0] OP_LDA = 4'd0;
  localparam logic [3:0] OP_STO = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_JMP = 4'd4;
  localparam logic [3:0] OP_JGE = 4'd5;
  localparam logic [3:0] OP_JNE = 4'd6;
  localparam logic [3:0] OP_STP = 4'd7;

  localparam logic [1:0]      ALU_PASS  = 2'b00;
  localparam logic [1:0]      ALU_ADD   = 2'b01;
  localparam logic [1:0]      ALU_SUB   = 2'b10;
  localparam logic [TO_W-1:0] TIMEOUT_C = TO_W'(TIMEOUT);

  state_e          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            bus_err_q, bus_err_d;
  logic            mem_op;
`ifdef MU0_CTRL_ILLEGAL_TRAP_EN
  logic            illegal_q, illegal_d;
`endif

  // Outputs are decoded from the current state so that strobes can follow
  // mem_ack in the same cycle and everything drops the moment rst_n falls.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    state_d   = state_q;
    cnt_d     = cnt_q;
    bus_err_d = bus_err_q;
`ifdef MU0_CTRL_ILLEGAL_TRAP_EN
    illegal_d = illegal_q;
`endif
    mem_op    = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = 1'b0;
    ir_ce     = 1'b0;
    pc_inc    = 1'b0;
    pc_load   = 1'b0;
    acc_ce    = 1'b0;
    alu_op    = ALU_PASS;
    halted    = 1'b0;

    unique case (state_q)
      S_IDLE: if (run) state_d = S_FETCH;
      S_FETCH: begin
        mem_op  = 1'b1;
        mem_req = 1'b1;
        ir_ce   = mem_ack;
        pc_inc  = mem_ack;
        if (mem_ack) state_d = S_EXEC;
      end
      S_EXEC: begin
        unique case (opcode)
          OP_LDA, OP_ADD, OP_SUB: begin
            mem_op   = 1'b1;
            mem_req  = 1'b1;
            addr_sel = 1'b1;
            alu_op   = (opcode == OP_ADD) ? ALU_ADD :
                       (opcode == OP_SUB) ? ALU_SUB : ALU_PASS;
            acc_ce   = mem_ack;
            if (mem_ack) state_d = S_FETCH;
          end
          OP_STO: begin
            mem_op   = 1'b1;
            mem_req  = 1'b1;
            mem_we   = 1'b1;
            addr_sel = 1'b1;
            if (mem_ack) state_d = S_FETCH;
          end
          OP_JMP: begin pc_load = 1'b1;      state_d = S_FETCH; end
          OP_JGE: begin pc_load = !acc_neg;  state_d = S_FETCH; end
          OP_JNE: begin pc_load = !acc_zero; state_d = S_FETCH; end
          OP_STP: state_d = S_HALT;
          default: begin
`ifdef MU0_CTRL_ILLEGAL_TRAP_EN
            state_d   = S_HALT;
            illegal_d = 1'b1;
`else
            state_d   = S_FETCH;
`endif
          end
        endcase
      end
      S_HALT: halted = 1'b1;
      default: state_d = S_IDLE;
    endcase

    // A stalled access that reaches the limit aborts; strobes are already 0 without ack.
    if (mem_op && !mem_ack && (cnt_q == TIMEOUT_C)) begin
      state_d   = S_HALT;
      bus_err_d = 1'b1;
    end

    if ((state_d != state_q) || (mem_op && mem_ack)) cnt_d = '0;
    else if (mem_op)                                 cnt_d = cnt_q + TO_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
`ifdef MU0_CTRL_ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
`ifdef MU0_CTRL_ILLEGAL_TRAP_EN
      illegal_q <= illegal_d;
`endif
    end
  end

  assign bus_err = bus_err_q;
`ifdef MU0_CTRL_ILLEGAL_TRAP_EN
  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_mu0_control_unit.sv
// Scoreboard bench for mu0_control_unit: each step pushes the expected output vector,
// which is popped and compared at the falling edge of that same cycle.
module tb_mu0_control_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic [3:0] opcode = 4'd0;
  logic       acc_zero = 1'b0;
  logic       acc_neg = 1'b0;
  logic       mem_ack = 1'b0;
  logic       mem_req, mem_we, addr_sel, ir_ce, pc_inc, pc_load, acc_ce;
  logic [1:0] alu_op;
  logic       halted, bus_err, illegal;

  mu0_control_unit #(.TIMEOUT(15), .TO_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode),
    .acc_zero(acc_zero), .acc_neg(acc_neg), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
    .ir_ce(ir_ce), .pc_inc(pc_inc), .pc_load(pc_load), .acc_ce(acc_ce),
    .alu_op(alu_op), .halted(halted), .bus_err(bus_err), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct { string name; logic [11:0] exp; } sb_t;
  typedef struct {
    logic r; logic [3:0] op; logic z; logic n; logic a; logic [11:0] exp;
  } step_t;

  sb_t sb[$];
  int  checks = 0;
  int  errors = 0;

  // Vector layout: req we addr_sel ir_ce pc_inc pc_load acc_ce alu_op[1:0] halted bus_err illegal
  function automatic logic [11:0] o(input logic req, we, as, ir, pi, pl, ac,
                                    input logic [1:0] alu, input logic h, be, il);
    return {req, we, as, ir, pi, pl, ac, alu, h, be, il};
  endfunction

  function automatic logic [11:0] outs();
    return {mem_req, mem_we, addr_sel, ir_ce, pc_inc, pc_load, acc_ce, alu_op,
            halted, bus_err, illegal};
  endfunction

  function automatic step_t st(input logic r, input logic [3:0] op,
                               input logic z, n, a, input logic [11:0] exp);
    step_t s;
    s.r = r; s.op = op; s.z = z; s.n = n; s.a = a; s.exp = exp;
    return s;
  endfunction

  logic [11:0] Z, FW, FA, LDA_A, ADD_W, ADD_A, STO_W, SUB_W, PL, HLT, HLT_BE, HLT_IL;

  task automatic apply_step(input string name, input step_t s);
    run = s.r; opcode = s.op; acc_zero = s.z; acc_neg = s.n; mem_ack = s.a;
    sb.push_back('{name, s.exp});
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; run = 1'b0; opcode = 4'd0; acc_zero = 1'b0; acc_neg = 1'b0; mem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step_t tbl[$];
    sb_t e;
    rst_n = 1'b0; run = 1'b1; mem_ack = 1'b1; opcode = 4'd2;
    sb.push_back('{"in_reset", Z});
    @(negedge clk);
    e = sb.pop_front(); checks++;
    if (outs() !== e.exp) begin
      errors++; $display("FAIL %s got %03h want %03h", e.name, outs(), e.exp);
    end
    do_reset();
    tbl.push_back(st(0, 4'd0, 0, 0, 1, Z));
    tbl.push_back(st(0, 4'd0, 0, 0, 0, Z));
    foreach (tbl[i]) begin
      apply_step("reset_idle", tbl[i]);
      e = sb.pop_front(); checks++;
      if (outs() !== e.exp) begin
        errors++; $display("FAIL %s step %0d got %03h want %03h", e.name, i, outs(), e.exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_fetch();
    step_t tbl[$];
    sb_t e;
    tbl.push_back(st(1, 4'd0, 0, 0, 1, Z));
    tbl.push_back(st(0, 4'd0, 0, 0, 1, FA));
    tbl.push_back(st(0, 4'd0, 0, 0, 1, LDA_A));
    tbl.push_back(st(0, 4'd0, 0, 0, 0, FW));
    foreach (tbl[i]) begin
      apply_step("fetch", tbl[i]);
      e = sb.pop_front(); checks++;
      if (outs() !== e.exp) begin
        errors++; $display("FAIL %s step %0d got %03h want %03h", e.name, i, outs(), e.exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_add_wait();
    step_t tbl[$];
    sb_t e;
    tbl.push_back(st(0, 4'd2, 0, 0, 1, FA));
    for (int k = 0; k < 3; k++) tbl.push_back(st(0, 4'd2, 0, 0, 0, ADD_W));
    tbl.push_back(st(0, 4'd2, 0, 0, 1, ADD_A));
    tbl.push_back(st(0, 4'd2, 0, 0, 0, FW));
    tbl.push_back(st(0, 4'd1, 0, 0, 1, FA));
    tbl.push_back(st(0, 4'd1, 0, 0, 0, STO_W));
    tbl.push_back(st(0, 4'd1, 0, 0, 1, STO_W));
    tbl.push_back(st(0, 4'd1, 0, 0, 0, FW));
    foreach (tbl[i]) begin
      apply_step("add_sto_wait", tbl[i]);
      e = sb.pop_front(); checks++;
      if (outs() !== e.exp) begin
        errors++; $display("FAIL %s step %0d got %03h want %03h", e.name, i, outs(), e.exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_jumps();
    step_t tbl[$];
    sb_t e;
    tbl.push_back(st(0, 4'd5, 0, 0, 1, FA));
    tbl.push_back(st(0, 4'd5, 0, 0, 0, PL));
    tbl.push_back(st(0, 4'd5, 0, 1, 1, FA));
    tbl.push_back(st(0, 4'd5, 0, 1, 0, Z));
    tbl.push_back(st(0, 4'd4, 1, 1, 1, FA));
    tbl.push_back(st(0, 4'd4, 1, 1, 1, PL));
    tbl.push_back(st(0, 4'd6, 1, 0, 1, FA));
    tbl.push_back(st(0, 4'd6, 1, 0, 0, Z));
    tbl.push_back(st(0, 4'd6, 0, 0, 1, FA));
    tbl.push_back(st(0, 4'd6, 0, 0, 0, PL));
    tbl.push_back(st(0, 4'd6, 0, 0, 0, FW));
    foreach (tbl[i]) begin
      apply_step("jumps", tbl[i]);
      e = sb.pop_front(); checks++;
      if (outs() !== e.exp) begin
        errors++; $display("FAIL %s step %0d got %03h want %03h", e.name, i, outs(), e.exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_halt();
    step_t tbl[$];
    sb_t e;
    do_reset();
    tbl.push_back(st(1, 4'd7, 0, 0, 0, Z));
    tbl.push_back(st(0, 4'd7, 0, 0, 1, FA));
    tbl.push_back(st(0, 4'd7, 0, 0, 1, Z));
    for (int k = 0; k < 3; k++) tbl.push_back(st(1, 4'd0, 0, 0, 1, HLT));
    foreach (tbl[i]) begin
      apply_step("halt", tbl[i]);
      e = sb.pop_front(); checks++;
      if (outs() !== e.exp) begin
        errors++; $display("FAIL %s step %0d got %03h want %03h", e.name, i, outs(), e.exp);
      end
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    sb.push_back('{"halt_reset", Z});
    #1;
    e = sb.pop_front(); checks++;
    if (outs() !== e.exp) begin
      errors++; $display("FAIL %s got %03h want %03h", e.name, outs(), e.exp);
    end
    do_reset();
  endtask

  task automatic test_timeout();
    step_t tbl[$];
    sb_t e;
    // Fetch stall: 16 request cycles without ack, then HALT with bus_err.
    do_reset();
    tbl.push_back(st(1, 4'd0, 0, 0, 0, Z));
    for (int k = 0; k < 16; k++) tbl.push_back(st(0, 4'd0, 0, 0, 0, FW));
    tbl.push_back(st(1, 4'd0, 0, 0, 1, HLT_BE));
    tbl.push_back(st(0, 4'd0, 0, 0, 0, HLT_BE));
    foreach (tbl[i]) begin
      apply_step("timeout_fetch", tbl[i]);
      e = sb.pop_front(); checks++;
      if (outs() !== e.exp) begin
        errors++; $display("FAIL %s step %0d got %03h want %03h", e.name, i, outs(), e.exp);
      end
      @(posedge clk); #1;
    end
    // Ack on the 16th cycle wins; then an execute-phase stall also times out.
    do_reset();
    tbl.delete();
    tbl.push_back(st(1, 4'd0, 0, 0, 0, Z));
    for (int k = 0; k < 15; k++) tbl.push_back(st(0, 4'd0, 0, 0, 0, FW));
    tbl.push_back(st(0, 4'd0, 0, 0, 1, FA));
    tbl.push_back(st(0, 4'd0, 0, 0, 1, LDA_A));
    tbl.push_back(st(0, 4'd3, 0, 0, 1, FA));
    for (int k = 0; k < 16; k++) tbl.push_back(st(0, 4'd3, 0, 0, 0, SUB_W));
    tbl.push_back(st(0, 4'd3, 0, 0, 0, HLT_BE));
    foreach (tbl[i]) begin
      apply_step("timeout_edge", tbl[i]);
      e = sb.pop_front(); checks++;
      if (outs() !== e.exp) begin
        errors++; $display("FAIL %s step %0d got %03h want %03h", e.name, i, outs(), e.exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal();
    step_t tbl[$];
    sb_t e;
    do_reset();
    tbl.push_back(st(1, 4'd9, 0, 0, 0, Z));
    tbl.push_back(st(0, 4'd9, 0, 0, 1, FA));
    tbl.push_back(st(0, 4'd9, 0, 0, 0, Z));
`ifdef MU0_CTRL_ILLEGAL_TRAP_EN
    tbl.push_back(st(1, 4'd9, 0, 0, 1, HLT_IL));
    tbl.push_back(st(0, 4'd0, 0, 0, 0, HLT_IL));
`else
    tbl.push_back(st(0, 4'd9, 0, 0, 0, FW));
    tbl.push_back(st(0, 4'd9, 0, 0, 1, FA));
`endif
    foreach (tbl[i]) begin
      apply_step("illegal", tbl[i]);
      e = sb.pop_front(); checks++;
      if (outs() !== e.exp) begin
        errors++; $display("FAIL %s step %0d got %03h want %03h", e.name, i, outs(), e.exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_async_reset();
    step_t tbl[$];
    sb_t e;
    do_reset();
    tbl.push_back(st(1, 4'd0, 0, 0, 0, Z));
    tbl.push_back(st(0, 4'd0, 0, 0, 0, FW));
    foreach (tbl[i]) begin
      apply_step("async_pre", tbl[i]);
      e = sb.pop_front(); checks++;
      if (outs() !== e.exp) begin
        errors++; $display("FAIL %s step %0d got %03h want %03h", e.name, i, outs(), e.exp);
      end
      if (i < tbl.size() - 1) begin @(posedge clk); #1; end
    end
    // Mid-access, between clock edges: everything must drop at once.
    mem_ack = 1'b1;
    #1 rst_n = 1'b0;
    sb.push_back('{"async_drop", Z});
    #1;
    e = sb.pop_front(); checks++;
    if (outs() !== e.exp) begin
      errors++; $display("FAIL %s got %03h want %03h", e.name, outs(), e.exp);
    end
    do_reset();
  endtask

  initial begin
    Z      = '0;
    FW     = o(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    FA     = o(1, 0, 0, 1, 1, 0, 0, 2'b00, 0, 0, 0);
    LDA_A  = o(1, 0, 1, 0, 0, 0, 1, 2'b00, 0, 0, 0);
    ADD_W  = o(1, 0, 1, 0, 0, 0, 0, 2'b01, 0, 0, 0);
    ADD_A  = o(1, 0, 1, 0, 0, 0, 1, 2'b01, 0, 0, 0);
    STO_W  = o(1, 1, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    SUB_W  = o(1, 0, 1, 0, 0, 0, 0, 2'b10, 0, 0, 0);
    PL     = o(0, 0, 0, 0, 0, 1, 0, 2'b00, 0, 0, 0);
    HLT    = o(0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0, 0);
    HLT_BE = o(0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 1, 0);
    HLT_IL = o(0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0, 1);

    test_reset();
    test_fetch();
    test_add_wait();
    test_jumps();
    test_halt();
    test_timeout();
    test_illegal();
    test_async_reset();

    if (sb.size() != 0) begin
      errors++; $display("FAIL scoreboard_leftover got %0d want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
